// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter
// Round-robin controller that shares an external bank of WIDTH JK flip-flops
// between NREQ requesters. Each granted request becomes one single-cycle j/k
// drive on one bit. The bank's q is then read back to confirm the result.
// Sequence per op: IDLE (arbitrate) -> DRIVE (grant + j/k) -> SAMPLE (done).

module jk_bank_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  localparam int IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int IDW   = (NREQ  > 1) ? $clog2(NREQ)  : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_i,
  input  logic [2*NREQ-1:0]    op_i,
  input  logic [NREQ*IDXW-1:0] idx_i,
  input  logic [WIDTH-1:0]     q_i,
  output logic [WIDTH-1:0]     j_o,
  output logic [WIDTH-1:0]     k_o,
  output logic [NREQ-1:0]      gnt_o,
  output logic                 done_o,
  output logic [IDW-1:0]       done_id_o,
  output logic                 bit_o,
  output logic                 err_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  // The op encoding maps directly onto the JK inputs: j = op[0], k = op[1].
  typedef enum logic [1:0] {
    OP_HOLD   = 2'd0,
    OP_SET    = 2'd1,
    OP_CLEAR  = 2'd2,
    OP_TOGGLE = 2'd3
  } op_t;

  state_t          state_q;
  logic [IDW-1:0]  ptr_q;      // last winner; search starts just above it
  logic [IDW-1:0]  id_q;
  op_t             op_q;
  logic [IDXW-1:0] idx_q;
  logic            old_q;      // q_i[idx] before the bank updated

  // Arbitration and drive-pattern results for the current IDLE cycle.
  logic            found;
  logic [IDW-1:0]  winner;
  logic [1:0]      sel_op;
  logic [IDXW-1:0] sel_idx;
  logic            sel_in_range;
  logic [WIDTH-1:0] j_nxt;
  logic [WIDTH-1:0] k_nxt;

  // Readback evaluation for the latched op.
  logic            idx_in_range;
  logic            q_bit;
  logic            expected;

  // Round-robin search from ptr+1 upward with wrap, then decode the winner's op.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    found        = 1'b0;
    winner       = ptr_q;
    sel_op       = 2'b00;
    sel_idx      = '0;
    sel_in_range = 1'b0;
    j_nxt        = '0;
    k_nxt        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int cand;
      cand = int'(ptr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && req_i[cand]) begin
        found  = 1'b1;
        winner = IDW'(cand);
      end
    end
    sel_op       = op_i[2*int'(winner) +: 2];
    sel_idx      = idx_i[int'(winner)*IDXW +: IDXW];
    sel_in_range = int'(sel_idx) < WIDTH;
    // An out-of-range index still gets a grant but never touches the bank.
    if (sel_in_range) begin
      j_nxt[sel_idx] = sel_op[0];
      k_nxt[sel_idx] = sel_op[1];
    end
  end

  // Readback: compare the bank bit against what the op should have produced.
  always_comb begin
    idx_in_range = int'(idx_q) < WIDTH;
    q_bit        = 1'b0;
    if (idx_in_range) q_bit = q_i[idx_q];
    unique case (op_q)
      OP_HOLD:   expected = old_q;
      OP_SET:    expected = 1'b1;
      OP_CLEAR:  expected = 1'b0;
      OP_TOGGLE: expected = ~old_q;
      default:   expected = old_q;
    endcase
    bit_o = 1'b0;
    err_o = 1'b0;
    if (state_q == SAMPLE) begin
      bit_o = q_bit;
      err_o = !idx_in_range || (q_bit != expected);
    end
  end

  // Control FSM with registered grant, drive and completion outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= IDW'(NREQ - 1);
      id_q      <= '0;
      op_q      <= OP_HOLD;
      idx_q     <= '0;
      old_q     <= 1'b0;
      j_o       <= '0;
      k_o       <= '0;
      gnt_o     <= '0;
      done_o    <= 1'b0;
      done_id_o <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, matching the hardware regardless of order.
      j_o       <= '0;
      k_o       <= '0;
      gnt_o     <= '0;
      done_o    <= 1'b0;
      done_id_o <= '0;
      unique case (state_q)
        IDLE: begin
          if (found) begin
            id_q    <= winner;
            op_q    <= op_t'(sel_op);
            idx_q   <= sel_idx;
            ptr_q   <= winner;
            gnt_o   <= NREQ'(1) << winner;
            j_o     <= j_nxt;
            k_o     <= k_nxt;
            state_q <= DRIVE;
          end
        end
        DRIVE: begin
          // The bank updates on this same edge, so q_i here is the old value.
          old_q     <= idx_in_range ? q_i[idx_q] : 1'b0;
          done_o    <= 1'b1;
          done_id_o <= id_q;
          state_q   <= SAMPLE;
        end
        SAMPLE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Protocol sanity checks (simulation only; ignored by synthesis).
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt_o));
  a_single_bit_drive: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(j_o | k_o));
  a_done_in_sample: assert property (@(posedge clk) disable iff (!rst_n)
    done_o |-> (state_q == SAMPLE));

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Testbench for jk_bank_arbiter: a JK bank model drives q_i, and a
// round-robin reference model predicts the grants and readback results.

module tb_jk_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance: NREQ=4, WIDTH=8
  logic [3:0]  req_i = '0;
  logic [7:0]  op_i = '0;
  logic [11:0] idx_i = '0;
  logic [7:0]  q_i, j_o, k_o;
  logic [3:0]  gnt_o;
  logic        done_o, bit_o, err_o;
  logic [1:0]  done_id_o;

  // Second instance: NREQ=2, WIDTH=6 (non power of two -> out-of-range possible)
  logic [1:0]  req6 = '0;
  logic [3:0]  op6 = '0;
  logic [5:0]  idx6 = '0;
  logic [5:0]  q6, j6, k6;
  logic [1:0]  gnt6;
  logic        done6, bit6, err6;
  logic [0:0]  done_id6;

  jk_bank_arbiter #(.NREQ(4), .WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .op_i(op_i), .idx_i(idx_i),
    .q_i(q_i), .j_o(j_o), .k_o(k_o), .gnt_o(gnt_o), .done_o(done_o),
    .done_id_o(done_id_o), .bit_o(bit_o), .err_o(err_o));

  jk_bank_arbiter #(.NREQ(2), .WIDTH(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .req_i(req6), .op_i(op6), .idx_i(idx6),
    .q_i(q6), .j_o(j6), .k_o(k6), .gnt_o(gnt6), .done_o(done6),
    .done_id_o(done_id6), .bit_o(bit6), .err_o(err6));

  // JK bank models; load_* preloads a value, ignore_k models a broken bank.
  logic [7:0] bank = '0, load_val = '0;
  logic       load_en = 1'b0, ignore_k = 1'b0;
  logic [5:0] bank6 = '0;
  assign q_i = bank;
  assign q6  = bank6;

  always @(posedge clk) begin
    if (load_en)       bank <= load_val;
    else if (ignore_k) bank <= bank | j_o;
    else               bank <= (j_o & ~bank) | (~k_o & bank);
    bank6 <= (j6 & ~bank6) | (~k6 & bank6);
  end

  int n_checks = 0;
  int n_fail   = 0;
  int ptr_m    = NREQ - 1;   // reference round-robin pointer

  // Reference: first requester above ptr_m (with wrap) that is requesting.
  function automatic int rr_pick(input logic [3:0] req);
    for (int k = 1; k <= NREQ; k++) begin
      int r;
      r = (ptr_m + k) % NREQ;
      if (req[r]) return r;
    end
    return -1;
  endfunction

  task automatic set_bank(input logic [7:0] v);
    load_val = v;
    load_en  = 1'b1;
    @(negedge clk);
    load_en  = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    req_i = '0;
    req6  = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = NREQ - 1;
  endtask

  // Runs one arbitration round starting in an IDLE cycle (at a negedge).
  task automatic run_op(input logic [3:0] req, input logic [7:0] ops,
                        input logic [11:0] idxs, input bit drop, output int winner);
    logic [1:0] op;
    logic [2:0] idx;
    logic [7:0] jexp, kexp;
    logic       old, ideal, obs, eerr;
    req_i  = req;
    op_i   = ops;
    idx_i  = idxs;
    winner = rr_pick(req);
    if (winner < 0) begin
      @(negedge clk);
      if (gnt_o !== 4'b0) begin n_fail++; $display("FAIL idle_gnt: got %b want 0000", gnt_o); end
      n_checks++;
      if (done_o !== 1'b0) begin n_fail++; $display("FAIL idle_done: got %b want 0", done_o); end
      n_checks++;
      return;
    end
    ptr_m = winner;
    op    = ops[2*winner +: 2];
    idx   = idxs[3*winner +: 3];
    jexp  = '0;
    kexp  = '0;
    jexp[idx] = (op == 2'd1) || (op == 2'd3);
    kexp[idx] = (op == 2'd2) || (op == 2'd3);
    @(negedge clk);  // DRIVE
    old = bank[idx];
    if (gnt_o !== 4'(1 << winner)) begin n_fail++; $display("FAIL gnt: got %b want %b", gnt_o, 4'(1 << winner)); end
    n_checks++;
    if (j_o !== jexp) begin n_fail++; $display("FAIL drive_j: got %h want %h", j_o, jexp); end
    n_checks++;
    if (k_o !== kexp) begin n_fail++; $display("FAIL drive_k: got %h want %h", k_o, kexp); end
    n_checks++;
    if (done_o !== 1'b0) begin n_fail++; $display("FAIL drive_done: got %b want 0", done_o); end
    n_checks++;
    if (drop) req_i[winner] = 1'b0;
    case (op)
      2'd0:    ideal = old;
      2'd1:    ideal = 1'b1;
      2'd2:    ideal = 1'b0;
      default: ideal = ~old;
    endcase
    obs  = ignore_k ? (old | jexp[idx]) : ideal;
    eerr = (obs != ideal);
    @(negedge clk);  // SAMPLE
    if (done_o !== 1'b1) begin n_fail++; $display("FAIL done: got %b want 1", done_o); end
    n_checks++;
    if (done_id_o !== 2'(winner)) begin n_fail++; $display("FAIL done_id: got %0d want %0d", done_id_o, winner); end
    n_checks++;
    if (bit_o !== obs) begin n_fail++; $display("FAIL bit: got %b want %b", bit_o, obs); end
    n_checks++;
    if (err_o !== eerr) begin n_fail++; $display("FAIL err: got %b want %b", err_o, eerr); end
    n_checks++;
    if ((j_o | k_o | 8'(gnt_o)) !== 8'h00) begin n_fail++; $display("FAIL sample_quiet: j %h k %h gnt %b want all 0", j_o, k_o, gnt_o); end
    n_checks++;
    @(negedge clk);  // back in IDLE
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    if ({j_o, k_o, gnt_o, done_o, done_id_o, bit_o, err_o} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: j %h k %h gnt %b done %b id %0d bit %b err %b want all 0",
                         j_o, k_o, gnt_o, done_o, done_id_o, bit_o, err_o);
    end
    n_checks++;
    if ({j6, k6, gnt6, done6, done_id6, bit6, err6} !== '0) begin
      n_fail++; $display("FAIL reset_outputs6: got nonzero, want all 0");
    end
    n_checks++;
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = NREQ - 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if ({gnt_o, done_o, j_o, k_o} !== '0) begin n_fail++; $display("FAIL idle_no_req: gnt %b done %b", gnt_o, done_o); end
      n_checks++;
    end
  endtask

  task automatic test_first_op();
    int w;
    set_bank(8'h00);
    run_op(4'b0001, {2'd0, 2'd0, 2'd0, 2'd1}, {3'd0, 3'd0, 3'd0, 3'd3}, 1'b1, w);
    if (bank !== 8'h08) begin n_fail++; $display("FAIL first_op_bank: got %h want 08", bank); end
    n_checks++;
  endtask

  task automatic test_round_robin();
    int w;
    int order [5] = '{0, 1, 2, 3, 0};
    reset_dut();
    set_bank(8'h00);
    for (int n = 0; n < 5; n++) begin
      run_op(4'b1111, {4{2'd3}}, 12'h000, 1'b0, w);
      if (w != order[n]) begin n_fail++; $display("FAIL rr_order: got %0d want %0d", w, order[n]); end
      n_checks++;
      if (bank[0] !== ((n % 2) == 0)) begin n_fail++; $display("FAIL rr_bit0: got %b at op %0d", bank[0], n); end
      n_checks++;
    end
    req_i = '0;
  endtask

  task automatic test_hold();
    int w;
    set_bank(8'h20);
    run_op(4'b0100, {2'd1, 2'd0, 2'd1, 2'd1}, {3'd1, 3'd5, 3'd1, 3'd1}, 1'b1, w);
    if (bank !== 8'h20) begin n_fail++; $display("FAIL hold_bank: got %h want 20", bank); end
    n_checks++;
  endtask

  task automatic test_ignore_k();
    int w;
    set_bank(8'h04);
    ignore_k = 1'b1;
    run_op(4'b1000, {2'd2, 2'd0, 2'd0, 2'd0}, {3'd2, 3'd0, 3'd0, 3'd0}, 1'b1, w);
    ignore_k = 1'b0;
  endtask

  task automatic test_out_of_range();
    // Out-of-range SET on idx 7 of a 6-bit bank
    req6 = 2'b01; op6 = 4'b0001; idx6 = 6'b000_111;
    @(negedge clk);  // DRIVE
    req6 = 2'b00;
    if (gnt6 !== 2'b01) begin n_fail++; $display("FAIL oor_gnt: got %b want 01", gnt6); end
    n_checks++;
    if ((j6 | k6) !== 6'h00) begin n_fail++; $display("FAIL oor_drive: j %h k %h want 0", j6, k6); end
    n_checks++;
    @(negedge clk);  // SAMPLE
    if ({done6, bit6, err6, j6, k6} !== {3'b101, 12'h000}) begin
      n_fail++; $display("FAIL oor_sample: done %b bit %b err %b j %h k %h want done 1 bit 0 err 1", done6, bit6, err6, j6, k6);
    end
    n_checks++;
    @(negedge clk);
    // In-range SET on idx 5 by requester 1 (pointer now 0 -> 1 wins)
    req6 = 2'b11; op6 = 4'b0101; idx6 = 6'b101_101;
    @(negedge clk);
    req6 = 2'b01;
    if (gnt6 !== 2'b10 || j6 !== 6'h20 || k6 !== 6'h00) begin
      n_fail++; $display("FAIL w6_drive: gnt %b j %h k %h want 10 20 00", gnt6, j6, k6);
    end
    n_checks++;
    @(negedge clk);
    if ({done6, done_id6, bit6, err6} !== 4'b1110) begin
      n_fail++; $display("FAIL w6_sample: done %b id %b bit %b err %b want 1 1 1 0", done6, done_id6, bit6, err6);
    end
    n_checks++;
    req6 = 2'b00;
    @(negedge clk);
    @(negedge clk);  // let the pending requester 0 op (if granted) drain
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_drive();
    int w;
    req_i = 4'b1111; op_i = {4{2'd1}}; idx_i = {4{3'd1}};
    @(negedge clk);  // DRIVE
    if (gnt_o === 4'b0000) begin n_fail++; $display("FAIL mid_pre_gnt: got %b want nonzero", gnt_o); end
    n_checks++;
    #2;
    rst_n = 1'b0;
    #1;
    if ({j_o, k_o, gnt_o} !== '0) begin n_fail++; $display("FAIL mid_async_clear: j %h k %h gnt %b want 0", j_o, k_o, gnt_o); end
    n_checks++;
    @(posedge clk);
    #1;
    if (done_o !== 1'b0) begin n_fail++; $display("FAIL mid_no_done: got %b want 0", done_o); end
    n_checks++;
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = NREQ - 1;
    run_op(4'b1111, {4{2'd0}}, {4{3'd2}}, 1'b1, w);
    if (w != 0) begin n_fail++; $display("FAIL mid_first_winner: got %0d want 0", w); end
    n_checks++;
    req_i = '0;
  endtask

  task automatic test_random();
    logic [3:0] pending, add;
    logic [1:0] rop [4];
    logic [2:0] ridx [4];
    logic [7:0] ops;
    logic [11:0] idxs;
    int w;
    set_bank(8'($urandom));
    pending = '0;
    for (int r = 0; r < 4; r++) begin rop[r] = '0; ridx[r] = '0; end
    for (int n = 0; n < 40; n++) begin
      add = 4'($urandom_range(0, 15)) & ~pending;
      for (int r = 0; r < 4; r++) begin
        if (add[r]) begin
          rop[r]  = 2'($urandom);
          ridx[r] = 3'($urandom);
        end
      end
      pending = pending | add;
      for (int r = 0; r < 4; r++) begin
        ops[2*r +: 2]  = rop[r];
        idxs[3*r +: 3] = ridx[r];
      end
      run_op(pending, ops, idxs, 1'b1, w);
      if (w >= 0) pending[w] = 1'b0;
    end
    req_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_first_op();
    test_round_robin();
    test_hold();
    test_ignore_k();
    test_out_of_range();
    test_reset_mid_drive();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_bank_arbiter.md
Name: jk_bank_arbiter

Overview:
- Round-robin controller that shares an external bank of WIDTH JK flip-flops between NREQ requesters.
- Each granted request is one bit operation: SET, CLEAR, TOGGLE or HOLD.
- The block converts the operation into a single-cycle j/k drive pattern, then reads the bank's q back to confirm the result.
- Sits between software-visible requesters and the JK bank; the bank's clk is this block's clk.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WIDTH, 8, number of JK flip-flops in the bank (2..256). Index width IDXW = clog2(WIDTH), derived internally.

Ports:
- clk  in  1  rising-edge clock, shared with the JK bank.
- rst_n  in  1  asynchronous active-low reset.
- req_i  in  NREQ  request per requester; held high until its gnt_o bit is seen.
- op_i  in  2*NREQ  2-bit op per requester, slice r = op_i[2r+1:2r]: 0 HOLD, 1 SET, 2 CLEAR, 3 TOGGLE.
- idx_i  in  NREQ*IDXW  target bit index per requester, slice r = idx_i[r*IDXW +: IDXW].
- q_i  in  WIDTH  current JK bank outputs.
- j_o  out  WIDTH  J drive to bank.
- k_o  out  WIDTH  K drive to bank.
- gnt_o  out  NREQ  one-hot grant, one-cycle pulse.
- done_o  out  1  one-cycle completion pulse.
- done_id_o  out  clog2(NREQ)  requester index of the completing op.
- bit_o  out  1  q_i[idx] after the op, valid with done_o.
- err_o  out  1  valid with done_o: readback mismatch or index out of range.

Behaviour:
- Reset (async assert, sync release): FSM to IDLE; j_o, k_o, gnt_o, done_o, done_id_o, bit_o, err_o all 0; round-robin pointer = NREQ-1, so requester 0 has first priority.
- FSM states are IDLE, DRIVE, SAMPLE; every transition is unconditional except IDLE->DRIVE. Sustained throughput is one op per 3 cycles.
- IDLE:
  - If any req_i is set, choose the first set bit searching from pointer+1 upward with wrap.
  - Latch the winner's id, op and idx. Update pointer = winner. Go to DRIVE.
  - If no req_i is set, stay in IDLE with all outputs 0.
- DRIVE (1 cycle):
  - gnt_o[id] = 1.
  - Drive only bit idx: HOLD j=0 k=0; SET j=1 k=0; CLEAR j=0 k=1; TOGGLE j=1 k=1. All other bits are j=k=0.
  - Latch old = q_i[idx]. The bank updates at the end of this cycle.
- SAMPLE (1 cycle):
  - j_o = k_o = 0. done_o = 1, done_id_o = id, bit_o = q_i[idx].
  - Expected value: HOLD old; SET 1; CLEAR 0; TOGGLE ~old.
  - err_o = (bit_o != expected). Go to IDLE.
- Requester handshake:
  - op and idx are sampled only in the IDLE cycle the arbitration occurs.
  - The requester must drop req_i in the cycle after it sees gnt_o (the SAMPLE cycle), so it is low by the next IDLE.
  - A requester that re-asserts req_i is re-queued behind all others by the round-robin.
- Index out of range (idx >= WIDTH, only possible when WIDTH is not a power of 2):
  - The grant is still issued, but j_o = k_o = 0 in DRIVE.
  - SAMPLE gives done_o = 1, bit_o = 0, err_o = 1.
- Simultaneous requests: exactly one grant per op; the others wait in IDLE. No requester waits more than NREQ-1 ops while its req_i stays high.
- Reset mid-op: j_o and k_o clear immediately and no done_o is issued. An in-flight requester must re-request.
- Outputs are registered, except bit_o and err_o, which are combinational from q_i in SAMPLE.

Test Plan:
- After reset, q_i=0x00, req_i=0001, op=SET, idx=3 -> gnt_o=0001 in cycle 2; j_o=0x08, k_o=0x00 in cycle 2; done_o=1, done_id_o=0, bit_o=1, err_o=0 in cycle 3 (bank model q=0x08).
- req_i=1111 held continuously, all ops TOGGLE idx=0 -> grants in order 0,1,2,3,0, one every 3 cycles; bank bit 0 alternates 1,0,1,0,1; err_o never set.
- Bank model forced to ignore k (CLEAR on a bit at 1) -> done_o with bit_o=1, err_o=1.
- WIDTH=6, op SET idx=7 -> j_o=k_o=0 throughout, done_o=1, bit_o=0, err_o=1.
- Assert rst_n=0 mid-DRIVE -> j_o, k_o, gnt_o go to 0 without waiting for a clock edge; no done_o; after release requester 0 wins first if its req_i is high.
- HOLD on idx 5 with q=0x20 -> j_o=k_o=0, bit_o=1, err_o=0.
